// File: rtl/led_switch_io.sv
// LED output register plus synchronised, debounced switch input for the IO decode stage.
// Switch read data is combinational from the debounced value; all state moves on clock.
module led_switch_io #(
    parameter int DB_CYCLES = 20000,
    parameter int CNT_W     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        led_ctrl,
    input  logic        switch_ctrl,
    input  logic        io_write,
    input  logic        io_read,
    input  logic [15:0] led_wdata,
    input  logic [15:0] switch_raw,
    output logic [15:0] led_out,
    output logic [15:0] switch_rdata,
    output logic        sw_changed
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

    logic [15:0]      sync1;
    logic [15:0]      sync2;
    logic [15:0]      cand;
    logic [15:0]      stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            led_out    <= 16'h0000;
            sync1      <= 16'h0000;
            sync2      <= 16'h0000;
            cand       <= 16'h0000;
            stable     <= 16'h0000;
            cnt        <= '0;
            sw_changed <= 1'b0;
        end else begin
            if (led_ctrl && io_write) begin
                led_out <= led_wdata;
            end

            sync1      <= switch_raw;
            sync2      <= sync1;
            sw_changed <= 1'b0;

            // Down-counter: reload on any change, terminal count at zero holds.
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= CNT_LOAD;
            end else if (cnt == '0) begin
                if (cand != stable) begin
                    stable     <= cand;
                    sw_changed <= 1'b1;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        switch_rdata = 16'h0000;
        if (switch_ctrl && io_read) begin
            switch_rdata = stable;
        end
    end

endmodule
